// File: rtl/dbus_sram_responder_pkg.sv
// Shared types for the dbus responder: request/response structs, the
// responder state encoding and a byte-lane mask helper.
package dbus_sram_responder_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dbus_rsp_state_t;

    // Expand an 8-bit byte strobe into a 64-bit bit mask (lane i -> bits 8i+7:8i).
    function automatic logic [63:0] MASK_LANES(input logic [7:0] strobe);
        logic [63:0] mask;
        for (int i = 0; i < 8; i++) begin
            mask[8*i +: 8] = {8{strobe[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/dbus_sram_array.sv
// Word-addressed 64-bit storage: combinational read port, synchronous
// byte-strobed write port. Contents are deliberately not reset.
module dbus_sram_array
    import dbus_sram_responder_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     writeEn,
    input  logic [$clog2(DEPTH)-1:0] writeIndex,
    input  logic [63:0]              writeData,
    input  logic [7:0]               writeStrobe,
    input  logic [$clog2(DEPTH)-1:0] readIndex,
    output logic [63:0]              readData
);

    logic [63:0] mem [DEPTH];
    logic [63:0] laneMask;

    assign laneMask = MASK_LANES(writeStrobe);

    // Read is combinational so the responder sees the pre-write value in its DONE cycle.
    assign readData = mem[readIndex];

    // Merge only the strobed byte lanes into the addressed word.
    always_ff @(posedge clk) begin
        if (writeEn) begin
            mem[writeIndex] <= (mem[writeIndex] & ~laneMask) | (writeData & laneMask);
        end
    end

endmodule

// File: rtl/dbus_sram_responder.sv
// Far-side dbus responder: accepts one request at a time, waits LATENCY
// cycles, then answers with data_ok and commits any byte-strobed write.
module dbus_sram_responder
    import dbus_sram_responder_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       busy,
    output logic       oob
);

    localparam int          AW   = $clog2(DEPTH);
    localparam int          CW   = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
    localparam logic [63:0] SPAN = 64'(DEPTH) * 64'd8;

    dbus_rsp_state_t stateReg;
    logic [CW-1:0]   counterReg;
    logic [63:0]     addrReg;
    logic [63:0]     dataReg;
    logic [7:0]      strobeReg;
    logic [2:0]      sizeReg;
    logic            busyReg;
    logic            doneReg;

    logic [63:0]     offset;
    logic [AW-1:0]   wordIndex;
    logic            outOfRange;
    logic            writeEn;
    logic [63:0]     readData;
    logic            unusedSize;

    // size is captured only so it can be probed when debugging a bus trace.
    assign unusedSize = ^sizeReg;

    // Range check and word index come from the latched address, so dreq
    // may change freely once the request has been accepted.
    assign offset     = addrReg - BASE_ADDR;
    assign outOfRange = (addrReg < BASE_ADDR) || (offset >= SPAN);
    assign wordIndex  = offset[AW+2:3];

    // A reset arriving in the DONE cycle must suppress the commit.
    assign writeEn = !reset && doneReg && !outOfRange && (strobeReg != 8'h00);

    dbus_sram_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk        (clk),
        .writeEn    (writeEn),
        .writeIndex (wordIndex),
        .writeData  (dataReg),
        .writeStrobe(strobeReg),
        .readIndex  (wordIndex),
        .readData   (readData)
    );

    // Request FSM: latch in IDLE, count down in BUSY, respond for one cycle in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg   <= IDLE;
            counterReg <= '0;
            addrReg    <= '0;
            dataReg    <= '0;
            strobeReg  <= '0;
            sizeReg    <= '0;
            busyReg    <= 1'b0;
            doneReg    <= 1'b0;
        end else begin
            unique case (stateReg)
                IDLE: begin
                    if (dreq.valid) begin
                        addrReg    <= dreq.addr;
                        dataReg    <= dreq.data;
                        strobeReg  <= dreq.strobe;
                        sizeReg    <= dreq.size;
                        counterReg <= CW'(LATENCY);
                        busyReg    <= 1'b1;
                        if (LATENCY == 0) begin
                            stateReg <= DONE;
                            doneReg  <= 1'b1;
                        end else begin
                            stateReg <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    counterReg <= counterReg - CW'(1);
                    if (counterReg == CW'(1)) begin
                        stateReg <= DONE;
                        doneReg  <= 1'b1;
                    end
                end
                DONE: begin
                    stateReg <= IDLE;
                    busyReg  <= 1'b0;
                    doneReg  <= 1'b0;
                end
                default: begin
                    stateReg <= IDLE;
                    busyReg  <= 1'b0;
                    doneReg  <= 1'b0;
                end
            endcase
        end
    end

    // Response: addr_ok only while idle; data is zero except in an in-range DONE cycle.
    always_comb begin
        dresp         = '0;
        dresp.addr_ok = !reset && (stateReg == IDLE) && dreq.valid;
        dresp.data_ok = !reset && doneReg;
        if (!reset && doneReg && !outOfRange) begin
            dresp.data = readData;
        end
    end

    assign busy = !reset && busyReg;
    assign oob  = !reset && doneReg && outOfRange;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder: two instances (LATENCY 2 and 0), a
// cycle-numbered transaction model checked every cycle, directed literal
// checks and randomized traffic.
module tb_dbus_sram_responder;
    import dbus_sram_responder_pkg::*;

    localparam int          DEPTH = 64;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          LAT0  = 2;
    localparam int          LAT1  = 0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    dbus_req_t  dreqs  [2];
    dbus_resp_t dresps [2];
    logic       busys  [2];
    logic       oobs   [2];

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            dbus_sram_responder #(
                .DEPTH    (DEPTH),
                .LATENCY  ((gi == 0) ? LAT0 : LAT1),
                .BASE_ADDR(BASE)
            ) u_dut (
                .clk  (clk),
                .reset(reset),
                .dreq (dreqs[gi]),
                .dresp(dresps[gi]),
                .busy (busys[gi]),
                .oob  (oobs[gi])
            );
        end
    endgenerate

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int latOf(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A request accepted in cycle c is answered in cycle c+1+LAT; the
    // responder is busy from c+1 through that answer cycle.
    bit          pend  [2];
    int          acc   [2];
    logic [63:0] mAddr [2];
    logic [63:0] mData [2];
    logic [7:0]  mStrb [2];
    logic [63:0] mem   [2][DEPTH];
    bit          known [2][DEPTH];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin : per_inst
            bit          isDone;
            bit          wasIdle;
            bit          inRange;
            logic [63:0] off;
            int          idx;
            if (reset) begin
                check($sformatf("i%0d rst addr_ok", i), 64'(dresps[i].addr_ok), 64'd0);
                check($sformatf("i%0d rst data_ok", i), 64'(dresps[i].data_ok), 64'd0);
                check($sformatf("i%0d rst data", i), dresps[i].data, 64'd0);
                check($sformatf("i%0d rst busy", i), 64'(busys[i]), 64'd0);
                check($sformatf("i%0d rst oob", i), 64'(oobs[i]), 64'd0);
                pend[i] = 1'b0;
            end else begin
                wasIdle = !pend[i];
                isDone  = pend[i] && (cyc == acc[i] + 1 + latOf(i));
                off     = mAddr[i] - BASE;
                inRange = (mAddr[i] >= BASE) && (off < 64'(DEPTH * 8));
                idx     = int'(off >> 3);
                check($sformatf("i%0d addr_ok", i), 64'(dresps[i].addr_ok), 64'(wasIdle && dreqs[i].valid));
                check($sformatf("i%0d data_ok", i), 64'(dresps[i].data_ok), 64'(isDone));
                check($sformatf("i%0d busy", i), 64'(busys[i]), 64'(pend[i]));
                check($sformatf("i%0d oob", i), 64'(oobs[i]), 64'(isDone && !inRange));
                if (isDone) begin
                    if (!inRange)
                        check($sformatf("i%0d data oob", i), dresps[i].data, 64'd0);
                    else if (known[i][idx])
                        check($sformatf("i%0d data", i), dresps[i].data, mem[i][idx]);
                    if (inRange && mStrb[i] != 8'h00) begin
                        for (int b = 0; b < 8; b++)
                            if (mStrb[i][b]) mem[i][idx][8*b +: 8] = mData[i][8*b +: 8];
                        known[i][idx] = known[i][idx] || (mStrb[i] == 8'hFF);
                    end
                    pend[i] = 1'b0;
                end else begin
                    check($sformatf("i%0d data idle", i), dresps[i].data, 64'd0);
                end
                if (wasIdle && dreqs[i].valid) begin
                    pend[i]  = 1'b1;
                    acc[i]   = cyc;
                    mAddr[i] = dreqs[i].addr;
                    mData[i] = dreqs[i].data;
                    mStrb[i] = dreqs[i].strobe;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic doTxn(input int i, input logic [63:0] a, input logic [7:0] s, input logic [63:0] d,
                         input bit scramble, output logic [63:0] rd, output int lat, output bit ob);
        bit accepted = 1'b0;
        bit done = 1'b0;
        int t = 0;
        dreqs[i].valid  = 1'b1;
        dreqs[i].addr   = a;
        dreqs[i].size   = 3'd3;
        dreqs[i].strobe = s;
        dreqs[i].data   = d;
        rd  = 64'd0;
        lat = -1;
        ob  = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (accepted) begin
                t++;
                if (dresps[i].data_ok) begin
                    done = 1'b1;
                    rd   = dresps[i].data;
                    ob   = oobs[i];
                    lat  = t;
                end
            end else if (dresps[i].addr_ok) begin
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
            if (accepted && !done && scramble) begin
                dreqs[i].addr   = {$urandom, $urandom};
                dreqs[i].data   = {$urandom, $urandom};
                dreqs[i].strobe = 8'($urandom);
            end
        end
        check($sformatf("i%0d txn completed", i), 64'(done), 64'd1);
    endtask

    task automatic idle(input int i, input int n);
        dreqs[i].valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic randomTraffic(input int i, input int n);
        logic [63:0] a;
        logic [63:0] rd;
        logic [7:0]  s;
        int          lat;
        bit          ob;
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 9) == 0)
                a = ($urandom_range(0, 1) == 0) ? BASE - 64'(8 * $urandom_range(1, 4))
                                                : BASE + 64'(DEPTH * 8) + 64'($urandom_range(0, 63));
            else
                a = BASE + 64'(8 * $urandom_range(0, 15)) + 64'($urandom_range(0, 7));
            s = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            doTxn(i, a, s, {$urandom, $urandom}, $urandom_range(0, 4) == 0, rd, lat, ob);
            check($sformatf("i%0d rnd latency", i), 64'(lat), 64'(latOf(i) + 1));
            idle(i, $urandom_range(0, 2));
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [63:0] rd;
        int          lat;
        int          c0;
        bit          ob;
        bit          acc0;
        dreqs[0] = '0;
        dreqs[1] = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset data_ok", 64'(dresps[0].data_ok), 64'd0);
        check("reset busy", 64'(busys[0]), 64'd0);
        @(posedge clk);
        #1;

        // LATENCY=2: full write then readback
        doTxn(0, 64'h8000_0010, 8'hFF, 64'hDEAD_BEEF_0123_4567, 1'b0, rd, lat, ob);
        check("wr latency", 64'(lat), 64'd3);
        check("wr oob", 64'(ob), 64'd0);
        idle(0, 1);
        doTxn(0, 64'h8000_0010, 8'h00, 64'd0, 1'b0, rd, lat, ob);
        check("rd latency", 64'(lat), 64'd3);
        check("rd data", rd, 64'hDEAD_BEEF_0123_4567);
        idle(0, 1);

        // partial write over the same word
        doTxn(0, 64'h8000_0010, 8'h0F, 64'h1111_1111_2222_2222, 1'b0, rd, lat, ob);
        idle(0, 1);
        doTxn(0, 64'h8000_0014, 8'h00, 64'd0, 1'b0, rd, lat, ob);
        check("partial rd data", rd, 64'hDEAD_BEEF_2222_2222);
        idle(0, 1);

        // out of range: array must stay untouched
        doTxn(0, BASE + 64'((DEPTH - 1) * 8), 8'hFF, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0, rd, lat, ob);
        doTxn(0, BASE, 8'hFF, 64'h5A5A_5A5A_5A5A_5A5A, 1'b0, rd, lat, ob);
        doTxn(0, 64'h7FFF_FFF8, 8'h00, 64'd0, 1'b0, rd, lat, ob);
        check("oob rd data", rd, 64'd0);
        check("oob rd flag", 64'(ob), 64'd1);
        doTxn(0, BASE + 64'(DEPTH * 8), 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, rd, lat, ob);
        check("oob wr data", rd, 64'd0);
        check("oob wr flag", 64'(ob), 64'd1);
        doTxn(0, BASE + 64'((DEPTH - 1) * 8), 8'h00, 64'd0, 1'b0, rd, lat, ob);
        check("last word kept", rd, 64'hA5A5_A5A5_A5A5_A5A5);
        doTxn(0, BASE, 8'h00, 64'd0, 1'b0, rd, lat, ob);
        check("word0 kept", rd, 64'h5A5A_5A5A_5A5A_5A5A);
        idle(0, 2);

        // request fields change after acceptance
        doTxn(0, BASE + 64'h28, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b1, rd, lat, ob);
        idle(0, 1);
        doTxn(0, BASE + 64'h28, 8'h00, 64'd0, 1'b1, rd, lat, ob);
        check("latched wr/rd data", rd, 64'h0123_4567_89AB_CDEF);
        idle(0, 1);

        // reset lands in the DONE cycle of a write
        dreqs[0].valid  = 1'b1;
        dreqs[0].addr   = BASE + 64'h28;
        dreqs[0].size   = 3'd3;
        dreqs[0].strobe = 8'hFF;
        dreqs[0].data   = 64'hFFFF_0000_FFFF_0000;
        acc0 = 1'b0;
        for (int k = 0; k < 10 && !acc0; k++) begin
            @(negedge clk);
            acc0 = dresps[0].addr_ok;
            @(posedge clk);
            #1;
        end
        check("rstdone accepted", 64'(acc0), 64'd1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        dreqs[0].valid = 1'b0;
        @(negedge clk);
        check("rstdone data_ok", 64'(dresps[0].data_ok), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        doTxn(0, BASE + 64'h28, 8'h00, 64'd0, 1'b0, rd, lat, ob);
        check("rstdone latency", 64'(lat), 64'd3);
        check("rstdone old value", rd, 64'h0123_4567_89AB_CDEF);
        idle(0, 1);

        // LATENCY=0: unwritten read, then back-to-back with valid held
        doTxn(1, BASE + 64'h38, 8'h00, 64'd0, 1'b0, rd, lat, ob);
        check("lat0 latency", 64'(lat), 64'd1);
        idle(1, 1);
        doTxn(1, BASE + 64'h10, 8'hFF, 64'hCAFE_F00D_1234_5678, 1'b0, rd, lat, ob);
        c0 = cyc;
        doTxn(1, BASE + 64'h10, 8'h00, 64'd0, 1'b0, rd, lat, ob);
        check("b2b spacing", 64'(cyc - c0), 64'd2);
        check("b2b latency", 64'(lat), 64'd1);
        check("b2b data", rd, 64'hCAFE_F00D_1234_5678);
        idle(1, 1);

        // randomized traffic on both instances at once
        fork
            randomTraffic(0, 150);
            randomTraffic(1, 150);
        join
        idle(0, 3);
        idle(1, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
